inst_fetch: RTL and testbench



---
 rtl/inst_fetch.sv | 57 +++++
 tb/tb_inst_fetch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// PC generation and fetch control in front of the instruction cache RAM.
// Pairs each one-cycle-late cache word with its PC and hands the pair to decode over valid/ready.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_en,
    input  logic [31:0]       jump_addr,
    output logic [ADDR_W-1:0] ic_addr,
    input  logic [31:0]       ic_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_reg;
    logic        v_reg;
    logic        fire;
    logic [31:0] req_pc;
    logic        unused_bits;

    // A jump squashes whatever is on the cache output this cycle; reset hides it too.
    assign out_valid = v_reg & ~jump_en & ~rst;
    assign fire      = out_valid & out_ready;
    assign out_pc    = pc_reg;
    assign out_inst  = ic_inst;

    // Holding req_pc at pc_reg during a stall makes the cache re-read the same word,
    // so out_inst stays stable without a local copy of the instruction.
    always_comb begin
        req_pc = pc_reg;
        if (jump_en) begin
            req_pc = {jump_addr[31:2], 2'b00};
        end else if (fire) begin
            req_pc = pc_reg + 32'd4;
        end
    end

    assign ic_addr     = req_pc[ADDR_W+1:2];
    assign unused_bits = &{1'b0, jump_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC_ALIGNED;
            v_reg  <= 1'b0;
        end else begin
            pc_reg <= req_pc;
            v_reg  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a one-cycle-latency cache model.
module tb_inst_fetch;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              jump_en = 1'b0;
    logic [31:0]       jump_addr = 32'h0;
    logic [ADDR_W-1:0] ic_addr;
    logic [31:0]       ic_inst = 32'h0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [31:0]       out_pc;
    logic [31:0]       out_inst;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    inst_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .jump_en(jump_en), .jump_addr(jump_addr),
        .ic_addr(ic_addr), .ic_inst(ic_inst), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
    );

    always #5 clk = ~clk;

    // Cache model: registered read, one cycle of latency.
    always @(posedge clk) ic_inst <= mem[ic_addr];

    // One line per accepted instruction.
    always @(negedge clk) begin
        if (out_valid && out_ready)
            $display("xfer pc=%h inst=%h", out_pc, out_inst);
    end

    function automatic logic [31:0] word_of(input int idx);
        return 32'hC0DE_0000 | 32'(idx);
    endfunction

    // Inputs change 2 time units after the rising edge; checks run 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1; jump_en = 1'b0; out_ready = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        next_cycle();
        rst = 1'b1; jump_en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_valid: got %b want 0", out_valid);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL cycle0_valid: got %b want 0", out_valid);
        end
        checks++;
        if (ic_addr !== 10'd0) begin
            errors++; $display("FAIL cycle0_addr: got %h want 0", ic_addr);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4*i) || out_inst !== word_of(i)) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, out_valid, out_pc, out_inst, 32'(4*i), word_of(i));
            end
            checks++;
            if (ic_addr !== 10'(i+1)) begin
                errors++; $display("FAIL stream_addr_%0d: got %h want %h", i, ic_addr, 10'(i+1));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        next_cycle();                 // pc 0
        next_cycle();                 // pc 4
        next_cycle();                 // pc 8
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_inst !== word_of(2) || ic_addr !== 10'd2) begin
                errors++;
                $display("FAIL stall_hold_%0d: got v=%b pc=%h inst=%h addr=%h want v=1 pc=8 inst=%h addr=2",
                         i, out_valid, out_pc, out_inst, ic_addr, word_of(2));
            end
        end
        next_cycle();
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_pc !== 32'h8 || ic_addr !== 10'd3) begin
            errors++; $display("FAIL stall_release: got pc=%h addr=%h want pc=8 addr=3", out_pc, ic_addr);
        end
        next_cycle();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'hC || out_inst !== word_of(3)) begin
            errors++; $display("FAIL stall_next: got v=%b pc=%h inst=%h want v=1 pc=c inst=%h",
                               out_valid, out_pc, out_inst, word_of(3));
        end
    endtask

    task automatic test_jump();
        do_reset();
        next_cycle();                 // pc 0
        next_cycle();                 // pc 4
        jump_en = 1'b1; jump_addr = 32'h0000_0103;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ic_addr !== 10'h40) begin
            errors++; $display("FAIL jump_cycle: got v=%b addr=%h want v=0 addr=40", out_valid, ic_addr);
        end
        next_cycle();
        jump_en = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== word_of(32'h40)) begin
            errors++; $display("FAIL jump_target: got v=%b pc=%h inst=%h want v=1 pc=100 inst=%h",
                               out_valid, out_pc, out_inst, word_of(32'h40));
        end
        next_cycle();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h104 || out_inst !== word_of(32'h41)) begin
            errors++; $display("FAIL jump_next: got v=%b pc=%h inst=%h want v=1 pc=104 inst=%h",
                               out_valid, out_pc, out_inst, word_of(32'h41));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        next_cycle();                 // pc 0
        next_cycle();                 // pc 4
        next_cycle();                 // pc 8, stall
        out_ready = 1'b0;
        next_cycle();
        out_ready = 1'b1; jump_en = 1'b1; jump_addr = 32'h0000_0200;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ic_addr !== 10'h80) begin
            errors++; $display("FAIL stall_jump: got v=%b addr=%h want v=0 addr=80", out_valid, ic_addr);
        end
        next_cycle();
        jump_en = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_inst !== word_of(32'h80)) begin
            errors++; $display("FAIL stall_jump_target: got v=%b pc=%h inst=%h want v=1 pc=200 inst=%h",
                               out_valid, out_pc, out_inst, word_of(32'h80));
        end
        next_cycle();
        jump_en = 1'b1; jump_addr = 32'h0000_0010;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ic_addr !== 10'h4) begin
            errors++; $display("FAIL b2b_first: got v=%b addr=%h want v=0 addr=4", out_valid, ic_addr);
        end
        next_cycle();
        jump_addr = 32'h0000_0020;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ic_addr !== 10'h8) begin
            errors++; $display("FAIL b2b_second: got v=%b addr=%h want v=0 addr=8", out_valid, ic_addr);
        end
        next_cycle();
        jump_en = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_inst !== word_of(8)) begin
            errors++; $display("FAIL b2b_target: got v=%b pc=%h inst=%h want v=1 pc=20 inst=%h",
                               out_valid, out_pc, out_inst, word_of(8));
        end
        next_cycle();
        #1;
        checks++;
        if (out_pc !== 32'h24 || out_inst !== word_of(9)) begin
            errors++; $display("FAIL b2b_next: got pc=%h inst=%h want pc=24 inst=%h", out_pc, out_inst, word_of(9));
        end
    endtask

    task automatic test_wrap();
        next_cycle();
        jump_en = 1'b1; jump_addr = 32'hFFFF_FFFE;
        #1;
        checks++;
        if (ic_addr !== 10'h3FF) begin
            errors++; $display("FAIL wrap_addr: got %h want 3ff", ic_addr);
        end
        next_cycle();
        jump_en = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_inst !== word_of(32'h3FF) || ic_addr !== 10'd0) begin
            errors++; $display("FAIL wrap_top: got v=%b pc=%h inst=%h addr=%h want v=1 pc=fffffffc inst=%h addr=0",
                               out_valid, out_pc, out_inst, ic_addr, word_of(32'h3FF));
        end
        next_cycle();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== word_of(0)) begin
            errors++; $display("FAIL wrap_zero: got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h",
                               out_valid, out_pc, out_inst, word_of(0));
        end
    endtask

    task automatic test_mid_reset();
        next_cycle();
        jump_en = 1'b1; jump_addr = 32'h0000_001C;
        next_cycle();
        jump_en = 1'b0;               // pc 1c fires
        next_cycle();
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h20) begin
            errors++; $display("FAIL mid_setup: got v=%b pc=%h want v=1 pc=20", out_valid, out_pc);
        end
        next_cycle();
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_valid0: got %b want 0", out_valid);
        end
        next_cycle();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_valid1: got %b want 0", out_valid);
        end
        next_cycle();
        rst = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ic_addr !== 10'd0) begin
            errors++; $display("FAIL mid_cycle0: got v=%b addr=%h want v=0 addr=0", out_valid, ic_addr);
        end
        next_cycle();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== word_of(0)) begin
            errors++; $display("FAIL mid_restart: got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h",
                               out_valid, out_pc, out_inst, word_of(0));
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = word_of(i);
        test_reset();
        test_stream();
        test_stall();
        test_jump();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
